qsn_inv_rotate_pc51: RTL and testbench

//  Inverse (de-rotation) cyclic shifter for the Pc=51, q=3 QSN datapath.

---
 rtl/qsn_inv_rotate_pc51.sv | 117 +++++++++++
 tb/tb_qsn_inv_rotate_pc51.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qsn_inv_rotate_pc51.sv
`default_nettype none
// ============================================================================
// Module   : qsn_inv_rotate_pc51
// Brief    : 3-stage pipelined inverse QSN de-rotator for PC=51 lanes of Q bits
// Revision : 1.0  initial release
// ============================================================================
module qsn_inv_rotate_pc51 #(
    parameter int PC      = 51,
    parameter int Q       = 3,
    parameter int SHIFT_W = 6
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PC*Q-1:0]      msg_in,
    input  logic [SHIFT_W-1:0]   shift_factor,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PC*Q-1:0]      msg_out,
    output logic                 shift_err
);

    localparam int W = PC * Q;

    logic               adv;
    logic               illegal_d;
    logic [SHIFT_W-1:0] s_eff_d;
    logic [SHIFT_W-1:0] r_d;
    logic [PC-1:0]      sel_d;

    logic               v1_q;
    logic [W-1:0]       msg1_q;
    logic [SHIFT_W-1:0] r1_q;
    logic [PC-1:0]      sel1_q;

    logic [SHIFT_W-1:0] rr1_d;
    logic [15:0]        lamt_d;
    logic [15:0]        ramt_d;
    logic [W-1:0]       lsh_d;
    logic [W-1:0]       rsh_d;

    logic               v2_q;
    logic [W-1:0]       lsh_q;
    logic [W-1:0]       rsh_q;
    logic [PC-1:0]      sel2_q;

    logic [W-1:0]       merged_d;
    logic               v3_q;
    logic [W-1:0]       msg3_q;
    logic               err_q;

    assign adv      = ~v3_q | out_ready;
    assign in_ready = adv;

    // Out-of-range shifts degrade to passthrough.
    assign illegal_d = (32'(shift_factor) >= 32'(PC));
    assign s_eff_d   = illegal_d ? '0 : shift_factor;
    assign r_d       = (s_eff_d == '0) ? '0 : (SHIFT_W'(PC) - s_eff_d);

    always_comb begin
        sel_d = '0;
        for (int k = 0; k < PC; k++) begin
            sel_d[k] = (k < (PC - int'(r_d)));
        end
    end

    // Left shifter drops lanes toward index 0 by r; right shifter fills the
    // vacated top lanes by PC-r (or 0 when r is 0).
    assign rr1_d  = (r1_q == '0) ? '0 : (SHIFT_W'(PC) - r1_q);
    assign lamt_d = 16'(r1_q) * 16'(Q);
    assign ramt_d = 16'(rr1_d) * 16'(Q);
    assign lsh_d  = msg1_q >> lamt_d;
    assign rsh_d  = msg1_q << ramt_d;

    for (genvar k = 0; k < PC; k++) begin : g_merge
        assign merged_d[k*Q +: Q] = sel2_q[k] ? lsh_q[k*Q +: Q] : rsh_q[k*Q +: Q];
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            v1_q   <= 1'b0;
            msg1_q <= '0;
            r1_q   <= '0;
            sel1_q <= '0;
            v2_q   <= 1'b0;
            lsh_q  <= '0;
            rsh_q  <= '0;
            sel2_q <= '0;
            v3_q   <= 1'b0;
            msg3_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (adv) begin
                v1_q   <= in_valid;
                msg1_q <= msg_in;
                r1_q   <= r_d;
                sel1_q <= sel_d;
                v2_q   <= v1_q;
                lsh_q  <= lsh_d;
                rsh_q  <= rsh_d;
                sel2_q <= sel1_q;
                v3_q   <= v2_q;
                msg3_q <= merged_d;
            end
            if (in_valid && adv && illegal_d) begin
                err_q <= 1'b1;
            end
        end
    end

    assign out_valid = v3_q;
    assign msg_out   = msg3_q;
    assign shift_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_qsn_inv_rotate_pc51.sv
`default_nettype none
// ============================================================================
// Module   : tb_qsn_inv_rotate_pc51
// Brief    : Directed self-checking bench for the PC=51 inverse QSN rotator
// Revision : 1.0  initial release
// ============================================================================
module tb_qsn_inv_rotate_pc51;

    localparam int PC = 51;
    localparam int Q  = 3;
    localparam int W  = PC * Q;

    logic          sys_clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  msg_in;
    logic [5:0]    shift_factor;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  msg_out;
    logic          shift_err;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  exp_beat;
    bit            last_acc;
    bit            last_drn;
    int            n_acc;
    int            n_drn;

    qsn_inv_rotate_pc51 dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .msg_in       (msg_in),
        .shift_factor (shift_factor),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .msg_out      (msg_out),
        .shift_err    (shift_err)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [W-1:0] lanes_mod8();
        logic [W-1:0] o;
        for (int k = 0; k < PC; k++) o[k*Q +: Q] = 3'(k % 8);
        return o;
    endfunction

    function automatic logic [W-1:0] rand_msg();
        logic [W-1:0] o;
        for (int k = 0; k < PC; k++) o[k*Q +: Q] = 3'($urandom_range(0, 7));
        return o;
    endfunction

    // out lane j = in lane (j - s) mod PC
    function automatic logic [W-1:0] derot(input logic [W-1:0] m, input int s);
        logic [W-1:0] o;
        for (int j = 0; j < PC; j++) o[j*Q +: Q] = m[((j - s + PC) % PC)*Q +: Q];
        return o;
    endfunction

    // upstream forward rotation that derot undoes
    function automatic logic [W-1:0] fwd(input logic [W-1:0] d, input int s);
        logic [W-1:0] o;
        for (int k = 0; k < PC; k++) o[k*Q +: Q] = d[((k + s) % PC)*Q +: Q];
        return o;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [W-1:0] m, input int s, input logic [W-1:0] e);
        in_valid     = 1'b1;
        msg_in       = m;
        shift_factor = 6'(s);
        exp_beat     = e;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    // One clock: score the handshake seen before the edge, then advance.
    task automatic cycle();
        #1;
        last_acc = !rst && in_valid && in_ready;
        last_drn = !rst && out_valid && out_ready;
        if (last_drn) begin
            if (exp_q.size() == 0) chk("spurious_out", W'(out_valid), '0);
            else chk("drain_data", msg_out, exp_q.pop_front());
            n_drn++;
        end
        if (last_acc) begin
            exp_q.push_back(exp_beat);
            n_acc++;
        end
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_out();
        for (int i = 0; i < 10; i++) begin
            if (out_valid) break;
            cycle();
        end
        chk("wait_out_valid", W'(out_valid), W'(1));
    endtask

    initial begin
        logic [W-1:0] m, d, held_val;
        logic [W-1:0] bp [6];
        bit           held;
        int           sent;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        msg_in = '0; shift_factor = '0; exp_beat = '0;
        n_acc = 0; n_drn = 0;
        repeat (3) cycle();
        chk("rst_out_valid", W'(out_valid), '0);
        chk("rst_msg_out", msg_out, '0);
        chk("rst_shift_err", W'(shift_err), '0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", W'(in_ready), W'(1));

        // identity and latency
        m = lanes_mod8();
        drive(m, 0, m);
        cycle(); idle();
        chk("lat_after_acc", W'(out_valid), '0);
        cycle();
        chk("lat_plus1", W'(out_valid), '0);
        cycle();
        chk("lat_plus2", W'(out_valid), W'(1));
        chk("identity", msg_out, m);
        cycle();

        // s=1: lane0 <- in lane 50 (=2), lane1 <- in lane 0 (=0), lane50 <- lane 49 (=1)
        drive(m, 1, derot(m, 1));
        cycle(); idle();
        wait_out();
        chk("s1_lane0", W'(msg_out[2:0]), W'(2));
        chk("s1_lane1", W'(msg_out[5:3]), W'(0));
        chk("s1_lane50", W'(msg_out[152:150]), W'(1));
        cycle();

        // s=50: lane0 <- in lane 1 (=1), lane49 <- lane 50 (=2), lane50 <- lane 0 (=0)
        drive(m, 50, derot(m, 50));
        cycle(); idle();
        wait_out();
        chk("s50_lane0", W'(msg_out[2:0]), W'(1));
        chk("s50_lane49", W'(msg_out[149:147]), W'(2));
        chk("s50_lane50", W'(msg_out[152:150]), W'(0));
        cycle();

        // round trip, back-to-back
        n_acc = 0; n_drn = 0;
        for (int s = 0; s < PC; s++) begin
            d = rand_msg();
            drive(fwd(d, s), s, d);
            cycle();
        end
        idle();
        repeat (3) cycle();
        chk("rt_accepts", W'(n_acc), W'(51));
        chk("rt_drains", W'(n_drn), W'(51));

        // backpressure mid-stream
        for (int i = 0; i < 6; i++) bp[i] = rand_msg();
        n_acc = 0; n_drn = 0; sent = 0; held = 1'b0; held_val = '0;
        for (int t = 0; t < 40 && n_drn < 6; t++) begin
            out_ready = !(t >= 4 && t < 8);
            if (sent < 6) drive(bp[sent], 7*sent + 3, derot(bp[sent], 7*sent + 3));
            else idle();
            #1;
            if (out_valid && !out_ready) chk("bp_in_ready", W'(in_ready), '0);
            if (held) chk("bp_stable", msg_out, held_val);
            held     = out_valid && !out_ready;
            held_val = msg_out;
            cycle();
            if (last_acc) sent++;
        end
        idle();
        out_ready = 1'b1;
        chk("bp_accepts", W'(n_acc), W'(6));
        chk("bp_drains", W'(n_drn), W'(6));
        chk("bp_queue_empty", W'(exp_q.size()), '0);

        // illegal shift while stalled is not accepted and must not flag
        m = rand_msg();
        drive(m, 5, derot(m, 5));
        cycle(); idle();
        wait_out();
        out_ready = 1'b0;
        drive(m, 55, m);
        cycle(); cycle();
        chk("err_unaccepted", W'(shift_err), '0);
        idle();
        out_ready = 1'b1;
        cycle();

        // accepted illegal shifts: passthrough, sticky flag
        m = rand_msg();
        drive(m, 51, m);
        cycle();
        chk("err_set", W'(shift_err), W'(1));
        d = rand_msg();
        drive(d, 63, d);
        cycle(); idle();
        repeat (4) cycle();
        chk("err_sticky", W'(shift_err), W'(1));
        chk("illegal_queue_empty", W'(exp_q.size()), '0);

        // reset with three beats in flight
        for (int i = 0; i < 3; i++) begin
            m = rand_msg();
            drive(m, i + 20, derot(m, i + 20));
            cycle();
        end
        idle();
        rst = 1'b1;
        cycle();
        chk("mid_rst_out_valid", W'(out_valid), '0);
        chk("mid_rst_msg_out", msg_out, '0);
        chk("mid_rst_shift_err", W'(shift_err), '0);
        exp_q.delete();
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", W'(in_ready), W'(1));
        m = rand_msg();
        drive(m, 10, derot(m, 10));
        cycle(); idle();
        chk("post_rst_lat0", W'(out_valid), '0);
        cycle();
        chk("post_rst_lat1", W'(out_valid), '0);
        cycle();
        chk("post_rst_lat2", W'(out_valid), W'(1));
        cycle();
        chk("final_queue_empty", W'(exp_q.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
